// File: rtl/store_buffer_pkg.sv
// Shared types and helpers for the posted-write store buffer.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
package store_buffer_pkg;

   // One buffered store: word address (byte address bits [31:2]) and data.
   typedef struct packed {
      logic [29:0] word;
      logic [31:0] data;
   } sb_entry_t;

   localparam int SB_DEPTH_DEFAULT = 4;

   // Pointer width for a power-of-two depth; the count uses one extra bit.
   function automatic int sb_ptr_w(input int depth);
      return $clog2(depth);
   endfunction

   // Rebuild a word-aligned byte address from a stored word address.
   function automatic logic [31:0] sb_byte_addr(input logic [29:0] word);
      return {word, 2'b00};
   endfunction

endpackage : store_buffer_pkg

// File: rtl/store_buffer_if.sv
// Bundles the core data port and the memory read/write ports of the store buffer.
// Latency: n/a (wiring only).
// Backpressure: full stalls the core; mem_req/mem_ack pace the memory side.
interface store_buffer_if;

   // core side
   logic        memwrite;
   logic [31:0] addr;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        full;
   logic        empty;
   logic        overflow;

   // memory async read port
   logic [31:0] rd_addr;
   logic [31:0] rd_data;

   // memory write port
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;

   // store buffer side
   modport slave (
      input  memwrite, addr, writedata, rd_data, mem_ack,
      output readdata, full, empty, overflow, rd_addr,
             mem_req, mem_addr, mem_wdata
   );

   // core + memory side
   modport master (
      output memwrite, addr, writedata, rd_data, mem_ack,
      input  readdata, full, empty, overflow, rd_addr,
             mem_req, mem_addr, mem_wdata
   );

endinterface : store_buffer_if

// File: rtl/store_buffer_fwd.sv
// Youngest-match search over the live buffer entries for load forwarding.
// Latency: combinational.
// Backpressure: none; purely a lookup.
module store_buffer_fwd
   import store_buffer_pkg::*;
#(
   parameter  int DEPTH = SB_DEPTH_DEFAULT,
   localparam int PW    = sb_ptr_w(DEPTH)
) (
   input  sb_entry_t     ent_i [DEPTH],
   input  logic [PW-1:0] head_i,
   input  logic [PW:0]   count_i,
   input  logic [29:0]   word_i,
   output logic          hit_o,
   output logic [31:0]   data_o
);

   logic [PW-1:0] idx;

   // Walk live entries from head (oldest) towards tail-1 (youngest); each later
   // match overrides the earlier one, so the surviving value is the youngest
   // store to this word, which is what tail-1-first priority selects.
   always_comb begin
      hit_o  = 1'b0;
      data_o = '0;
      idx    = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head_i + PW'(i);
         if (((PW+1)'(i) < count_i) && (ent_i[idx].word == word_i)) begin
            hit_o  = 1'b1;
            data_o = ent_i[idx].data;
         end
      end
   end

endmodule : store_buffer_fwd

// File: rtl/store_buffer.sv
// Posted-write FIFO between core data port and memory, with load forwarding.
// Latency: store to mem_req 1 cycle; one memory write per cycle with mem_ack high.
// Backpressure: registered full stalls the core; mem_ack low holds the head.
// Optional: define STORE_BUFFER_COALESCE_EN to merge a store into the youngest
// non-head entry when it hits the same word.
module store_buffer
   import store_buffer_pkg::*;
#(
   parameter int DEPTH = SB_DEPTH_DEFAULT
) (
   input  logic          clk,
   input  logic          reset,     // asynchronous, active low
   store_buffer_if.slave bus
);

   localparam int          PW       = sb_ptr_w(DEPTH);
   localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

   // entry storage; deliberately not reset, the pointers define what is live
   sb_entry_t     ent_q [DEPTH];

   logic [PW-1:0] head_q,  head_d;
   logic [PW-1:0] tail_q,  tail_d;
   logic [PW:0]   count_q, count_d;
   logic          full_q,  full_d;
   logic          empty_q, empty_d;
   logic          overflow_q, overflow_d;

   logic [29:0]   core_word;
   logic          mem_req;
   logic          push;
   logic          pop;
   logic          merge;
   logic          wr_en;
   logic [PW-1:0] wr_idx;
   sb_entry_t     wr_ent;

   logic          fwd_hit;
   logic [31:0]   fwd_data;

   assign core_word = bus.addr[31:2];

   // The head is always being requested, so writes may only land on tail or,
   // when coalescing, on the youngest entry once it is distinct from head.
`ifdef STORE_BUFFER_COALESCE_EN
   logic [PW-1:0] youngest;
   assign youngest = tail_q - PW'(1);
   assign merge    = bus.memwrite
                     && (count_q >= (PW+1)'(2))
                     && (ent_q[youngest].word == core_word);
   assign wr_idx   = merge ? youngest : tail_q;
`else
   assign merge    = 1'b0;
   assign wr_idx   = tail_q;
`endif

   assign mem_req = ~empty_q;
   assign push    = bus.memwrite & ~full_q & ~merge;
   assign pop     = mem_req & bus.mem_ack;
   assign wr_en   = push | merge;
   assign wr_ent  = '{word: core_word, data: bus.writedata};

   // Pointer/count next state; full/empty are derived from the post-edge count
   // so they can be registered and never depend on the same-cycle store strobe.
   always_comb begin
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      if (push) begin
         tail_d = tail_q + PW'(1);
      end
      if (pop) begin
         head_d = head_q + PW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + (PW+1)'(1);
         2'b01:   count_d = count_q - (PW+1)'(1);
         default: count_d = count_q;
      endcase
      full_d     = (count_d == CNT_FULL);
      empty_d    = (count_d == '0);
      // a store dropped while full is an error the core should never cause
      overflow_d = overflow_q | (bus.memwrite & full_q & ~merge);
   end

   // Control state; reset drops mem_req at once and abandons any pending write.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         overflow_q <= 1'b0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         full_q     <= full_d;
         empty_q    <= empty_d;
         overflow_q <= overflow_d;
      end
   end

   // Entry write port: new store at tail, or overwrite of the youngest on merge.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         ent_q[wr_idx] <= wr_ent;
      end
   end

   store_buffer_fwd #(
      .DEPTH (DEPTH)
   ) u_fwd (
      .ent_i   (ent_q),
      .head_i  (head_q),
      .count_i (count_q),
      .word_i  (core_word),
      .hit_o   (fwd_hit),
      .data_o  (fwd_data)
   );

   // Loads see buffered stores first; memory only when nothing matches. The
   // head stays visible until its ack edge, after which memory holds it.
   assign bus.readdata  = fwd_hit ? fwd_data : bus.rd_data;
   assign bus.rd_addr   = bus.addr;

   assign bus.full      = full_q;
   assign bus.empty     = empty_q;
   assign bus.overflow  = overflow_q;

   assign bus.mem_req   = mem_req;
   assign bus.mem_addr  = sb_byte_addr(ent_q[head_q].word);
   assign bus.mem_wdata = ent_q[head_q].data;

endmodule : store_buffer

// File: doc/store_buffer.md
# store_buffer

Posted-write store buffer between the single-cycle MIPS core's data port and data memory. Core stores (`memwrite`, `aluout`, `writedata`) are captured into a small FIFO in one cycle and drained to memory over a req/ack write port, so slow memory writes do not lengthen the core cycle. Loads read memory combinationally, with forwarding from the youngest buffered store to the same word. `full` is the core's stall input.

## Interface
- `DEPTH`, 4: number of entries; power of two, 2..16.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `memwrite`  in  1  core store strobe for this cycle.
- `addr`  in  32  core byte address (`aluout`); only `[31:2]` used.
- `writedata`  in  32  core store data.
- `readdata`  out  32  load data to core, combinational.
- `full`  out  1  registered; count == DEPTH; core must stall.
- `empty`  out  1  registered; count == 0.
- `overflow`  out  1  sticky error; store presented while full.
- `rd_addr`  out  32  memory async read address; equals `addr`.
- `rd_data`  in  32  memory async read data.
- `mem_req`  out  1  write request; head entry valid.
- `mem_addr`  out  32  head entry address, `{word, 2'b00}`.
- `mem_wdata`  out  32  head entry data.
- `mem_ack`  in  1  memory accepted head write at this edge.

## Operation
- Circular FIFO: head/tail pointers of log2(DEPTH) bits wrap modulo DEPTH; a count of log2(DEPTH)+1 bits separates full from empty.
- Push: `memwrite & ~full` writes `{addr[31:2], writedata}` at tail on the clock edge; tail++ and count++.
- Store while `full`: no write and no pointer change; `overflow` sets and holds until reset.
- Drain: `mem_req = ~empty`. `mem_addr`/`mem_wdata` come from head and stay stable while `mem_req` is high and `mem_ack` is low.
- `mem_ack & mem_req` at an edge: head++ and count--.
- `mem_ack` with `mem_req` low is ignored.
- Push and pop at the same edge: count unchanged; both pointers advance.
- Push and pop at the same edge with `full` high is not possible, because push requires `~full`.
- Forwarding: `readdata` = data of the youngest valid entry whose word address equals `addr[31:2]`; if no entry matches, `readdata = rd_data`.
- The head entry is forwarded in the cycle its ack arrives; after the edge, memory holds the value.
- Reset: pointers and count go to 0, `overflow` to 0, and `mem_req` drops to 0 at once. A pending write is discarded and memory is left unwritten. Entry storage is not cleared.

## Timing
- Reset values: `full`=0, `empty`=1, `overflow`=0, `mem_req`=0.
- `readdata` and `rd_addr` are combinational from `addr` and the entries.
- Store to `mem_req` high: 1 cycle when the buffer was empty.
- Memory write throughput: at most one per cycle, when `mem_ack` is held high.
- `full` and `empty` reflect count after the edge; the core sees the stall in the cycle after the DEPTH-th push.
- `mem_ack` may assert in the first cycle `mem_req` is high.

## Configuration
- Macro `STORE_BUFFER_COALESCE_EN`.
- Defined: a store merges into the youngest entry instead of pushing when all of these hold:
  - `memwrite` is high;
  - count ≥ 2;
  - `addr[31:2]` matches the youngest entry's word address.
- On merge: data is overwritten, pointers and count are unchanged, and `overflow` is not set, even when `full`.
- The head entry is never merged, because it is under request.
- Undefined: every store pushes; there is no merge logic.

## Structure
- Package `store_buffer_pkg`:
  - `sb_entry_t` struct `{logic [29:0] word; logic [31:0] data;}`;
  - `SB_DEPTH_DEFAULT` = 4;
  - function `sb_ptr_w(depth)` returning the log2 width.
- Sub-module `store_buffer_fwd`: combinational youngest-match priority search over the entries, from tail-1 back to head, with a hit output and the forwarded data.

## Test plan
- Reset release with idle inputs: `empty`=1, `mem_req`=0, and `readdata` follows `rd_data`=0x1234.
- Store 0xAAAA5555 to 0x40 with `mem_ack` low: the next cycle `mem_req`=1, `mem_addr`=0x40, `mem_wdata`=0xAAAA5555. A load of 0x40 (0x43 also) returns 0xAAAA5555 while `rd_data`=0. Ack once: `empty`=1.
- Stores 1,2,3,4 to 0x0,0x4,0x8,0xC with no ack:
  - `full`=1 after the fourth;
  - a fifth store to 0x10 sets `overflow`, and nothing is pushed;
  - acks give memory writes in order 0x0..0xC.
- Stores 5 then 9 to 0x20 with an older entry at head:
  - load 0x20 returns 9;
  - with the macro, count rises by 1 and one write of 9 reaches 0x20;
  - without it, count rises by 2 and writes 5 then 9.
- Push and ack at the same edge with count=2: count stays 2, and head/tail wrap correctly across 8 iterations.
- Reset asserted mid-request with `mem_req`=1: `mem_req`=0 immediately, and no `mem_ack` write is counted after reset.
